// File: rtl/cluster_cg_domain_ctrl.sv
// cluster_cg_domain_ctrl: per-domain idle-hysteresis clock gating with isolation and timed wake.
// Ports:
//   clk_i, rstn_i   ungated cluster clock, synchronous active-low reset
//   test_mode_i     forces every gating cell transparent (FSMs unaffected)
//   cg_en_i         per-domain permission to gate
//   idle_thresh_i   idle cycles required before isolation, shared by all domains
//   busy_i          per-domain busy
//   incoming_req_i  per-domain pending request
//   events_i        asynchronous wake events, synchronised internally
//   isolate_o       per-domain interface isolation request
//   gated_o         per-domain clock-stopped status
//   domain_clk_o    per-domain gated clocks

module cluster_clock_gating (
   input  logic clk_i,
   input  logic en_i,
   input  logic test_en_i,
   output logic clk_o
);
   logic en_l;
   // Enable is captured while the clock is low so the gated clock never glitches.
   always_latch if (!clk_i) en_l = en_i | test_en_i;
   assign clk_o = clk_i & en_l;
endmodule

module cluster_cg_domain_ctrl #(
   parameter int NB_DOMAINS  = 4,
   parameter int IDLE_CNT_W  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ISO_CYCLES  = 2,
   parameter int WAKE_CYCLES = 2
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  test_mode_i,
   input  logic [NB_DOMAINS-1:0] cg_en_i,
   input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
   input  logic [NB_DOMAINS-1:0] busy_i,
   input  logic [NB_DOMAINS-1:0] incoming_req_i,
   input  logic [NB_DOMAINS-1:0] events_i,
   output logic [NB_DOMAINS-1:0] isolate_o,
   output logic [NB_DOMAINS-1:0] gated_o,
   output logic [NB_DOMAINS-1:0] domain_clk_o
);
   localparam int PH_MAX = (ISO_CYCLES > WAKE_CYCLES) ? ISO_CYCLES : WAKE_CYCLES;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   typedef enum logic [2:0] {ACTIVE, IDLE, ISO, GATED, WAKE} state_t;

   logic [SYNC_STAGES-1:0][NB_DOMAINS-1:0] ev_sync;
   logic [NB_DOMAINS-1:0]                  clk_en;

   always_ff @(posedge clk_i)
      if (!rstn_i) ev_sync <= '0;
      else         ev_sync <= {ev_sync[SYNC_STAGES-2:0], events_i};

   for (genvar g = 0; g < NB_DOMAINS; g++) begin : g_dom
      state_t                st, st_n;
      logic [IDLE_CNT_W-1:0] cnt, cnt_n;
      logic [PH_W-1:0]       ph, ph_n;
      logic                  wake, leave;
      assign wake  = busy_i[g] | incoming_req_i[g] | ev_sync[SYNC_STAGES-1][g];
      assign leave = wake | !cg_en_i[g];
      always_ff @(posedge clk_i)
         if (!rstn_i) begin
            st  <= ACTIVE;
            cnt <= '0;
            ph  <= '0;
         end else begin
            st  <= st_n;
            cnt <= cnt_n;
            ph  <= ph_n;
         end
      always_comb begin
         st_n  = st;
         cnt_n = cnt;
         ph_n  = ph;
         case (st)
            ACTIVE: if (!leave) begin
               st_n  = IDLE;
               cnt_n = '0;
            end
            // >= so a threshold lowered below the running count ends IDLE at once.
            IDLE: if (leave) st_n = ACTIVE;
            else if (cnt >= idle_thresh_i) begin
               st_n  = ISO;
               cnt_n = '0;
               ph_n  = '0;
            end else if (cnt != '1) cnt_n = cnt + 1'b1;
            ISO: if (leave) begin
               st_n = WAKE;
               ph_n = '0;
            end else if (ph == PH_W'(ISO_CYCLES - 1)) st_n = GATED;
            else ph_n = ph + 1'b1;
            GATED: if (leave) begin
               st_n = WAKE;
               ph_n = '0;
            end
            WAKE: if (ph == PH_W'(WAKE_CYCLES - 1)) st_n = ACTIVE;
            else ph_n = ph + 1'b1;
            default: st_n = ACTIVE;
         endcase
      end
      assign isolate_o[g] = st inside {ISO, GATED, WAKE};
      assign gated_o[g]   = st == GATED;
      assign clk_en[g]    = st != GATED;
      cluster_clock_gating u_cg (
         .clk_i    (clk_i),
         .en_i     (clk_en[g]),
         .test_en_i(test_mode_i),
         .clk_o    (domain_clk_o[g])
      );
   end
endmodule
